// File: rtl/dmem_responder.sv
// Data-memory responder for the multicycle core: doubleword ld/sd over a
// valid/ready request channel and a valid/ready response channel, with
// WAIT_CYCLES programmable wait states between acceptance and response.
// Optional byte strobes on stores are enabled by defining DMEM_BYTE_STROBE_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [7:0]  req_wstrb,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [63:0] ByteLimit = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  WaitLast  = 4'(WAIT_CYCLES);
  localparam bit          ZeroWait  = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cnt_last;

  // Captured request, isolates the access from later req_* activity.
  logic        write_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic [7:0]  req_strb;

  logic        accept;
  logic        commit;
  logic        c_write;
  logic [63:0] c_addr;
  logic [63:0] c_wdata;
  logic [7:0]  c_wstrb;
  logic        c_err;
  logic [AW-1:0] c_idx;

  logic [63:0] mem [DEPTH_WORDS];

`ifdef DMEM_BYTE_STROBE_EN
  assign req_strb = req_wstrb;
`else
  assign req_strb = 8'hFF;
`endif

  assign cnt_last = (cnt_q + 4'd1) == WaitLast;

  // State and wait-counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 4'd0;
        if (req_valid) begin
          state_d = ZeroWait ? StResp : StWait;
        end
      end
      StWait: begin
        if (cnt_last) begin
          state_d = StResp;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs and commit-source selection.
  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    accept    = req_ready && req_valid;
    commit    = ((state_q == StWait) && cnt_last) || (ZeroWait && accept);
    // With zero wait states the commit happens on the accept edge, so the
    // live request lines feed it instead of the not-yet-loaded capture regs.
    if (state_q == StIdle) begin
      c_write = req_write;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_wstrb = req_strb;
    end else begin
      c_write = write_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_wstrb = wstrb_q;
    end
    c_err = (c_addr[2:0] != 3'd0) || (c_addr >= ByteLimit);
    c_idx = c_addr[3 +: AW];
  end

  // Request capture on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      wstrb_q <= 8'd0;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_strb;
    end
  end

  // Response registers: loaded at commit, valid dropped on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 64'd0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_valid <= 1'b1;
      rsp_err   <= c_err;
      rsp_rdata <= (!c_write && !c_err) ? mem[c_idx] : 64'd0;
    end else if ((state_q == StResp) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Storage array; not cleared by reset, and reset blocks any pending write.
  always_ff @(posedge clk) begin
    if (commit && c_write && !c_err && !reset) begin
      for (int i = 0; i < 8; i++) begin
        if (c_wstrb[i]) begin
          mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, scoreboarded bench for dmem_responder. One instance uses the
// default WAIT_CYCLES=2, a second uses WAIT_CYCLES=0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid0;
  logic        req_write;
  logic [63:0] req_addr, req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [7:0]  req_wstrb;
`endif
  logic        rsp_ready, rsp_ready0;

  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [63:0] rsp_rdata;
  logic        req_ready0, rsp_valid0, rsp_err0, busy0;
  logic [63:0] rsp_rdata0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_wstrb (req_wstrb),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid0),
    .req_ready (req_ready0),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_wstrb (req_wstrb),
`endif
    .rsp_valid (rsp_valid0),
    .rsp_ready (rsp_ready0),
    .rsp_rdata (rsp_rdata0),
    .rsp_err   (rsp_err0),
    .busy      (busy0)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] mdl [int];
  int          checks = 0;
  int          errors = 0;
  bit          sel = 1'b0;

  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_busy;
  logic [63:0] o_rsp_rdata;
  assign o_req_ready = sel ? req_ready0 : req_ready;
  assign o_rsp_valid = sel ? rsp_valid0 : rsp_valid;
  assign o_rsp_err   = sel ? rsp_err0   : rsp_err;
  assign o_rsp_rdata = sel ? rsp_rdata0 : rsp_rdata;
  assign o_busy      = sel ? busy0      : busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) req_valid0 = v;
    else req_valid = v;
  endtask

  task automatic set_ready(input logic v);
    if (sel) rsp_ready0 = v;
    else rsp_ready = v;
  endtask

  // Push the model's expectation, run one transaction, compare on response.
  task automatic xact(input bit z, input logic wr, input logic [63:0] a,
                      input logic [63:0] d, input logic [7:0] s, input int hold);
    exp_t        e;
    int          lat;
    int          key;
    logic        err;
    logic [63:0] w;
    logic [7:0]  m;
    sel = z;
    err = (a[2:0] != 3'd0) || (a >= 64'h800);
    key = int'(a[10:3]) + (z ? 1000 : 0);
    e.err   = err;
    e.rdata = 64'd0;
`ifdef DMEM_BYTE_STROBE_EN
    m = s;
`else
    m = s | 8'hFF;  // full-word stores when strobes are absent
`endif
    if (!err) begin
      w = mdl.exists(key) ? mdl[key] : 64'hx;
      if (wr) begin
        for (int i = 0; i < 8; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
        mdl[key] = w;
      end else begin
        e.rdata = w;
      end
    end
    sbq.push_back(e);

    req_write = wr;
    req_addr  = a;
    req_wdata = d;
`ifdef DMEM_BYTE_STROBE_EN
    req_wstrb = s;
`endif
    set_valid(1'b1);
    lat = 0;
    while (!o_req_ready && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("accept_wait", 64'(lat < 20), 64'd1);
    @(posedge clk); #1;
    // Scramble the request lines after acceptance; the response must not care.
    set_valid(1'b0);
    req_addr  = ~a;
    req_wdata = ~d;
    req_write = ~wr;
    lat = 0;
    while (!o_rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 64'(lat), z ? 64'd0 : 64'd2);
    e = sbq.pop_front();
    check("rsp_err", 64'(o_rsp_err), 64'(e.err));
    check("rsp_rdata", o_rsp_rdata, e.rdata);
    for (int i = 0; i < hold; i++) begin
      set_valid(1'b1);
      @(posedge clk); #1;
      check("hold_valid", 64'(o_rsp_valid), 64'd1);
      check("hold_rdata", o_rsp_rdata, e.rdata);
      check("hold_req_ready", 64'(o_req_ready), 64'd0);
    end
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    check("hs_valid_drop", 64'(o_rsp_valid), 64'd0);
    check("hs_idle_ready", 64'(o_req_ready), 64'd1);
    set_valid(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_valid0 = 1'b0;
    req_write  = 1'b0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
`ifdef DMEM_BYTE_STROBE_EN
    req_wstrb  = 8'hFF;
`endif
    rsp_ready  = 1'b0;
    rsp_ready0 = 1'b0;
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid0", 64'(rsp_valid0), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    xact(0, 1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0);
    xact(0, 0, 64'h10, 64'h0, 8'hFF, 0);
    xact(0, 0, 64'h13, 64'h0, 8'hFF, 0);
    xact(0, 1, 64'h13, 64'h1234_5678, 8'hFF, 0);
    xact(0, 0, 64'h10, 64'h0, 8'hFF, 0);
    xact(0, 1, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 0);
    xact(0, 1, 64'h800, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 0);
    xact(0, 0, 64'h0, 64'h0, 8'hFF, 0);
    xact(0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'hFF, 0);
    xact(0, 0, 64'h10, 64'h0, 8'hFF, 5);
    xact(0, 1, 64'h18, 64'h1, 8'hFF, 0);
    xact(0, 1, 64'h18, 64'h2, 8'hFF, 0);
    xact(0, 0, 64'h18, 64'h0, 8'hFF, 0);
    xact(0, 1, 64'h7F8, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
    xact(0, 0, 64'h7F8, 64'h0, 8'hFF, 0);

    // Reset during WAIT of sd 0x20 must abort the store.
    xact(0, 1, 64'h20, 64'h55AA_55AA_55AA_55AA, 8'hFF, 0);
    xact(0, 0, 64'h10, 64'h0, 8'hFF, 0);
    sel       = 1'b0;
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = 64'h1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #2;
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_rdata", rsp_rdata, 64'd0);
    check("mid_rst_rsp_err", 64'(rsp_err), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    xact(0, 0, 64'h20, 64'h0, 8'hFF, 0);

    // Zero-wait instance.
    xact(1, 1, 64'h30, 64'h7777_8888_9999_AAAA, 8'hFF, 0);
    xact(1, 0, 64'h30, 64'h0, 8'hFF, 0);
    xact(1, 0, 64'h34, 64'h0, 8'hFF, 2);

`ifdef DMEM_BYTE_STROBE_EN
    xact(0, 1, 64'h10, 64'h1111_1111_1111_1111, 8'hFF, 0);
    xact(0, 1, 64'h10, 64'h2222_2222_2222_2222, 8'h0F, 0);
    xact(0, 0, 64'h10, 64'h0, 8'h00, 0);
    check("strobe_merge", mdl[2], 64'h1111_1111_2222_2222);
    xact(0, 1, 64'h10, 64'h3333_3333_3333_3333, 8'h00, 0);
    xact(0, 0, 64'h10, 64'h0, 8'hFF, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the multicycle RISC-V core.
- Serves doubleword load/store requests from the control FSM and datapath: ld, sd, and the address held in AOut.
- Uses a valid/ready request channel and a valid/ready response channel, with a programmable number of wait states.
- Replaces the single-cycle combinational memory, so the control FSM stalls in its memory-access states until the response handshake completes.

Parameters:
- DEPTH_WORDS, 256, number of 64-bit doublewords stored; power of two, minimum 2.
- WAIT_CYCLES, 2, extra cycles between request acceptance and response; range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store (sd), 0 = load (ld).
- req_addr  input  64  byte address.
- req_wdata  input  64  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  64  load data.
- rsp_err  output  1  misaligned or out-of-range access.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter 0. Memory contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: capture req_write, req_addr and req_wdata into internal registers, then go to WAIT. If WAIT_CYCLES=0, go directly to RESP and perform the commit on this edge.
- WAIT:
  - req_ready=0; counter counts 1..WAIT_CYCLES.
  - On the edge where the count reaches WAIT_CYCLES, perform the commit and go to RESP.
- Commit:
  - Error check: err = (addr[2:0]!=0) or (addr >= DEPTH_WORDS*8).
  - Store without error: mem[addr[3 +: log2(DEPTH_WORDS)]] <= wdata.
  - Load without error: rsp_rdata <= the addressed word.
  - Store, or any error: rsp_rdata <= 0.
  - rsp_err <= err, rsp_valid <= 1.
  - No memory write on error.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On the handshake edge: rsp_valid <= 0, go to IDLE.
  - No new request can be accepted in the same cycle as the response handshake.
- Latency:
  - Request accepted at edge T.
  - rsp_valid is high in the cycle after edge T+WAIT_CYCLES. For WAIT_CYCLES=0, it is high in the cycle after edge T.
  - Minimum initiation interval is WAIT_CYCLES+2 cycles.
- Captured request registers isolate the responder: changes on req_* lines after acceptance have no effect.
- Reset mid-operation:
  - Any reset before the commit edge aborts the access with no memory write.
  - Reset while in RESP drops the pending response.
- Back-to-back stores to the same address: the later store wins.
- A load issued after a store returns the stored data.

Optional Feature:
- Macro: DMEM_BYTE_STROBE_EN.
- Defined:
  - Extra input port req_wstrb [7:0].
  - It is captured with the request; at commit, only bytes i with wstrb[i]=1 are written.
  - A store with wstrb=0 completes normally with no change to memory.
  - Loads ignore wstrb.
  - The alignment rule is unchanged.
- Not defined:
  - The port is absent.
  - Stores always write all 8 bytes.

Test Plan:
- Reset, then sd addr=0x10 wdata=0xDEADBEEF_CAFEF00D with WAIT_CYCLES=2 -> rsp_valid rises 3 cycles after acceptance, rsp_err=0, rsp_rdata=0. A following ld at 0x10 returns 0xDEADBEEF_CAFEF00D.
- ld addr=0x13 -> rsp_err=1, rsp_rdata=0. sd addr=0x13 -> rsp_err=1 and memory is unchanged; verify by ld 0x10.
- sd addr=DEPTH_WORDS*8 (0x800 for the default) -> rsp_err=1, no wrap-around write to word 0.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready=0, and a second req_valid is not accepted until the cycle after the handshake.
- Assert reset during WAIT of sd 0x20 data=0x1 -> outputs return to reset values and a later ld 0x20 returns the prior contents. Also cover WAIT_CYCLES=0, where rsp_valid rises 1 cycle after acceptance.
- With DMEM_BYTE_STROBE_EN defined: sd 0x10 data=0x1111_1111_1111_1111 wstrb=0xFF, then sd 0x10 data=0x2222_2222_2222_2222 wstrb=0x0F -> ld 0x10 returns 0x1111_1111_2222_2222.
